// File: rtl/apb_master_if.sv
// Command/response and APB bus bundle for apb_master.
// Handshake: a transfer occurs on a rising edge where valid && ready; the sender holds valid and its payload until that edge.
interface apb_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB master: one command in, one APB transfer, one response out.
// Wait states are bounded by TIMEOUT; an expired wait completes with rsp_err=1.
module apb_master #(
    parameter int TIMEOUT = 16
) (
    input  logic         pclk,
    input  logic         preset,
    apb_master_if.master bus,
    output logic [1:0]   state_dbg
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_next;

    assign wait_next = wait_cnt + 8'd1;
    assign state_dbg = state;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state         <= IDLE;
            wait_cnt      <= 8'd0;
            bus.cmd_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'd0;
            bus.rsp_err   <= 1'b0;
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.pwrite    <= 1'b0;
            bus.paddr     <= 32'd0;
            bus.pwdata    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        bus.pwrite    <= bus.cmd_write;
                        bus.paddr     <= bus.cmd_addr;
                        bus.pwdata    <= bus.cmd_wdata;
                        bus.psel      <= 1'b1;
                        bus.cmd_ready <= 1'b0;
                        wait_cnt      <= 8'd0;
                        state         <= SETUP;
                    end else begin
                        // cmd_ready rises on the first edge after reset release
                        bus.cmd_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    bus.penable <= 1'b1;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    if (bus.pready) begin
                        bus.psel      <= 1'b0;
                        bus.penable   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= bus.pslverr;
                        bus.rsp_rdata <= (!bus.pwrite && !bus.pslverr) ? bus.prdata : 32'd0;
                        state         <= RESP;
                    end else if (wait_next == TIMEOUT_CNT) begin
                        bus.psel      <= 1'b0;
                        bus.penable   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rdata <= 32'd0;
                        wait_cnt      <= wait_next;
                        state         <= RESP;
                    end else begin
                        wait_cnt <= wait_next;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master (TIMEOUT=4): inputs driven and outputs sampled on the falling edge.
module tb_apb_master;
    logic       pclk;
    logic       preset;
    logic [1:0] state_dbg;
    int         tests_run;
    int         tests_failed;

    apb_master_if bus();

    apb_master #(.TIMEOUT(4)) dut (
        .pclk      (pclk),
        .preset    (preset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Presents a command at a falling edge and returns at the falling edge of SETUP.
    task automatic issue_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
        int guard;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        guard = 0;
        while (!bus.cmd_ready && guard < 10) begin
            @(negedge pclk);
            guard++;
        end
        tests_run++;
        if (!bus.cmd_ready) begin
            tests_failed++;
            $display("FAIL cmd_accept: cmd_ready=%0b required 1", bus.cmd_ready);
        end
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
    endtask

    // Acts as the slave from SETUP; returns at the first falling edge with psel low.
    task automatic run_access(input int waits, input logic err, input logic [31:0] rd,
                              output int n_pen, output bit unstable);
        logic [31:0] a0;
        logic [31:0] d0;
        logic        w0;
        int          guard;
        a0 = bus.paddr; d0 = bus.pwdata; w0 = bus.pwrite;
        n_pen = 0; unstable = 1'b0; guard = 0;
        @(negedge pclk);
        while (bus.psel && guard < 40) begin
            if (bus.penable) n_pen++;
            if (bus.paddr !== a0 || bus.pwdata !== d0 || bus.pwrite !== w0) unstable = 1'b1;
            if (n_pen == waits + 1) begin
                bus.pready = 1'b1; bus.pslverr = err; bus.prdata = rd;
            end else begin
                bus.pready = 1'b0; bus.pslverr = 1'b1; bus.prdata = 32'h0BAD_F00D;
            end
            guard++;
            @(negedge pclk);
        end
        bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = 32'h0;
        tests_run++;
        if (bus.psel !== 1'b0) begin
            tests_failed++;
            $display("FAIL access_exit: psel=%0b required 0 within budget", bus.psel);
        end
    endtask

    task automatic consume_rsp();
        bus.rsp_ready = 1'b1;
        @(negedge pclk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++;
        if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: psel=%0b penable=%0b rsp_valid=%0b cmd_ready=%0b required 0 0 0 0",
                     bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready);
        end
        tests_run++;
        if (bus.paddr !== 32'd0 || bus.pwdata !== 32'd0 || bus.pwrite !== 1'b0 ||
            bus.rsp_rdata !== 32'd0 || bus.rsp_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_data: paddr=%h pwdata=%h pwrite=%0b rdata=%h err=%0b required zeros",
                     bus.paddr, bus.pwdata, bus.pwrite, bus.rsp_rdata, bus.rsp_err);
        end
        preset = 1'b0;
        @(negedge pclk);
        tests_run++;
        if (bus.cmd_ready !== 1'b1 || state_dbg !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_release: cmd_ready=%0b state=%0d required 1 0", bus.cmd_ready, state_dbg);
        end
    endtask

    task automatic test_write();
        int n; bit uns;
        issue_cmd(1'b1, 32'd5, 32'hDEAD_BEEF);
        tests_run++;
        if (bus.psel !== 1'b1 || bus.penable !== 1'b0 || bus.paddr !== 32'd5 ||
            bus.pwrite !== 1'b1 || bus.pwdata !== 32'hDEAD_BEEF || bus.cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_setup: psel=%0b penable=%0b paddr=%h pwrite=%0b pwdata=%h cmd_ready=%0b required 1 0 5 1 deadbeef 0",
                     bus.psel, bus.penable, bus.paddr, bus.pwrite, bus.pwdata, bus.cmd_ready);
        end
        run_access(0, 1'b0, 32'h1111_2222, n, uns);
        tests_run++;
        if (n != 1 || uns) begin
            tests_failed++;
            $display("FAIL write_access: penable_cycles=%0d unstable=%0b required 1 0", n, uns);
        end
        tests_run++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'd0 ||
            bus.cmd_ready !== 1'b0 || bus.penable !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_rsp: valid=%0b err=%0b rdata=%h cmd_ready=%0b penable=%0b required 1 0 0 0 0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.cmd_ready, bus.penable);
        end
        consume_rsp();
        tests_run++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || state_dbg !== 2'd0) begin
            tests_failed++;
            $display("FAIL write_idle: valid=%0b cmd_ready=%0b state=%0d required 0 1 0",
                     bus.rsp_valid, bus.cmd_ready, state_dbg);
        end
    endtask

    task automatic test_read_wait();
        int n; bit uns;
        issue_cmd(1'b0, 32'd5, 32'h0);
        run_access(2, 1'b0, 32'hDEAD_BEEF, n, uns);
        tests_run++;
        if (n != 3 || uns) begin
            tests_failed++;
            $display("FAIL read_wait_access: penable_cycles=%0d unstable=%0b required 3 0", n, uns);
        end
        tests_run++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL read_wait_rsp: valid=%0b err=%0b rdata=%h required 1 0 deadbeef",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
        consume_rsp();
    endtask

    task automatic test_slverr();
        int n; bit uns;
        issue_cmd(1'b1, 32'd40, 32'h0000_00AA);
        run_access(0, 1'b1, 32'hFFFF_FFFF, n, uns);
        tests_run++;
        if (n != 1 || bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'd0) begin
            tests_failed++;
            $display("FAIL slverr_rsp: penable_cycles=%0d valid=%0b err=%0b rdata=%h required 1 1 1 0",
                     n, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
        consume_rsp();
    endtask

    task automatic test_timeout();
        int n; bit uns;
        issue_cmd(1'b0, 32'h100, 32'h0);
        run_access(255, 1'b0, 32'h0, n, uns);
        tests_run++;
        if (n != 4 || bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'd0) begin
            tests_failed++;
            $display("FAIL timeout_rsp: penable_cycles=%0d valid=%0b err=%0b rdata=%h required 4 1 1 0",
                     n, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
        consume_rsp();
        // pready on the last allowed wait cycle still completes normally
        issue_cmd(1'b0, 32'h104, 32'h0);
        run_access(3, 1'b0, 32'hA5A5_5A5A, n, uns);
        tests_run++;
        if (n != 4 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'hA5A5_5A5A) begin
            tests_failed++;
            $display("FAIL timeout_edge: penable_cycles=%0d err=%0b rdata=%h required 4 0 a5a55a5a",
                     n, bus.rsp_err, bus.rsp_rdata);
        end
        consume_rsp();
    endtask

    task automatic test_rsp_hold();
        int n; bit uns; bit bad;
        issue_cmd(1'b0, 32'd8, 32'h0);
        run_access(0, 1'b0, 32'h1357_9BDF, n, uns);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 32'h77; bus.cmd_wdata = 32'h55;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h1357_9BDF || bus.rsp_err !== 1'b0 ||
                bus.cmd_ready !== 1'b0 || bus.psel !== 1'b0) bad = 1'b1;
            @(negedge pclk);
        end
        tests_run++;
        if (bad || bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h1357_9BDF) begin
            tests_failed++;
            $display("FAIL rsp_hold: rdata=%h valid=%0b cmd_ready=%0b required 13579bdf 1 0 held",
                     bus.rsp_rdata, bus.rsp_valid, bus.cmd_ready);
        end
        bus.cmd_valid = 1'b0;
        consume_rsp();
        @(negedge pclk);
        tests_run++;
        if (state_dbg !== 2'd0 || bus.psel !== 1'b0 || bus.paddr !== 32'd8) begin
            tests_failed++;
            $display("FAIL rsp_hold_ignore: state=%0d psel=%0b paddr=%h required 0 0 8",
                     state_dbg, bus.psel, bus.paddr);
        end
    endtask

    task automatic test_back_to_back();
        int accepts; int rsps; bit overlap;
        accepts = 0; rsps = 0; overlap = 1'b0;
        bus.pready = 1'b1; bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 32'h200; bus.cmd_wdata = 32'h1;
        for (int i = 0; i < 12; i++) begin
            if (bus.cmd_valid && bus.cmd_ready) accepts++;
            if (bus.rsp_valid) rsps++;
            if (bus.rsp_valid && bus.cmd_ready) overlap = 1'b1;
            if (bus.penable && !bus.psel) overlap = 1'b1;
            @(negedge pclk);
        end
        bus.cmd_valid = 1'b0;
        @(negedge pclk);
        bus.pready = 1'b0; bus.rsp_ready = 1'b0;
        tests_run++;
        if (accepts != 3 || rsps != 3 || overlap) begin
            tests_failed++;
            $display("FAIL back_to_back: accepts=%0d rsps=%0d overlap=%0b required 3 3 0", accepts, rsps, overlap);
        end
    endtask

    task automatic test_reset_mid();
        int n; bit uns; bit saw_rsp;
        issue_cmd(1'b1, 32'h300, 32'hCAFE);
        @(negedge pclk);
        #2 preset = 1'b1;
        #1;
        tests_run++;
        if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_async: psel=%0b penable=%0b rsp_valid=%0b required 0 0 0",
                     bus.psel, bus.penable, bus.rsp_valid);
        end
        @(negedge pclk);
        preset = 1'b0;
        saw_rsp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            if (bus.rsp_valid || bus.psel) saw_rsp = 1'b1;
        end
        tests_run++;
        if (saw_rsp || bus.cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_release: stray=%0b cmd_ready=%0b required 0 1", saw_rsp, bus.cmd_ready);
        end
        issue_cmd(1'b0, 32'h304, 32'h0);
        run_access(0, 1'b0, 32'h0F0F_0F0F, n, uns);
        tests_run++;
        if (n != 1 || bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0F0F_0F0F) begin
            tests_failed++;
            $display("FAIL reset_mid_fresh: penable_cycles=%0d valid=%0b err=%0b rdata=%h required 1 1 0 0f0f0f0f",
                     n, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
        consume_rsp();
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        preset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h0; bus.cmd_wdata = 32'h0;
        bus.rsp_ready = 1'b0; bus.prdata = 32'h0; bus.pready = 1'b0; bus.pslverr = 1'b0;
        repeat (2) @(negedge pclk);
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_rsp_hold();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
